// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg -- shared definitions for the countdown timer controller.
//   state_t       : encoded controller state (also driven out for display/debug)
//   CUR_*         : one-hot cursor constants, bit0 = sec0 ... bit5 = hrs1
//   MAX_UNITS/TENS: largest legal value of a units digit / a tens-of-sec/min digit
//   digit_inc()   : wrap-around increment of one edit digit by position
// -----------------------------------------------------------------------------
package timer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SET   = 3'd1,
      ST_RUN   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_ALARM = 3'd4
   } state_t;

   localparam int N_DIGITS = 6;

   localparam logic [5:0] CUR_SEC0 = 6'b000001;
   localparam logic [5:0] CUR_SEC1 = 6'b000010;
   localparam logic [5:0] CUR_MIN0 = 6'b000100;
   localparam logic [5:0] CUR_MIN1 = 6'b001000;
   localparam logic [5:0] CUR_HRS0 = 6'b010000;
   localparam logic [5:0] CUR_HRS1 = 6'b100000;

   localparam logic [3:0] MAX_UNITS = 4'd9;
   localparam logic [3:0] MAX_TENS  = 4'd5;

   // Tens-of-seconds (1) and tens-of-minutes (3) roll over at 5; all others at 9.
   function automatic logic [3:0] digit_max(input int idx);
      return (idx == 1 || idx == 3) ? MAX_TENS : MAX_UNITS;
   endfunction

   // '>=' rather than '==' so an out-of-range value copied from the datapath
   // still returns to 0 on the next press.
   function automatic logic [3:0] digit_inc(input logic [3:0] d, input int idx);
      return (d >= digit_max(idx)) ? 4'd0 : d + 4'd1;
   endfunction

endpackage

// File: rtl/btn_edge.sv
// -----------------------------------------------------------------------------
// btn_edge -- registered rising-edge detector for one debounced button.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   btn   : debounced button level
//   pulse : one-cycle strobe on each 0->1 transition of btn
// The detector stays disarmed for the first clock after reset so that a button
// already held while reset is released does not register as a press.
// -----------------------------------------------------------------------------
module btn_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);

   logic prev;
   logic armed;

   // NOTE: sequential state uses non-blocking '<=' so every register samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev  <= 1'b0;
         armed <= 1'b0;
      end else begin
         prev  <= btn;
         armed <= 1'b1;
      end
   end

   assign pulse = armed & btn & ~prev;

endmodule

// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl -- control FSM for a six-digit countdown timer.
//   clk, rst           : clock, asynchronous active-low reset
//   tick_1hz           : one-cycle strobe per second
//   btn_*              : debounced button levels (mode/left/right/up/start)
//   t_sec0..t_hrs1     : current countdown digits from the datapath
//   t_zero             : datapath "all digits zero"
//   cursor             : one-hot edit digit select
//   n_sec0..n_hrs1     : edit values presented to the datapath
//   load               : datapath load qualifier (high throughout SET)
//   run_en             : count strobe, tick_1hz gated by RUN
//   alarm              : high while in ALARM
//   state              : encoded FSM state
// -----------------------------------------------------------------------------
module timer_ctrl
   import timer_pkg::*;
#(
   parameter int ALARM_SECS = 30,
   parameter int CNT_W      = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       btn_mode,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_up,
   input  logic       btn_start,
   input  logic [3:0] t_sec0,
   input  logic [3:0] t_sec1,
   input  logic [3:0] t_min0,
   input  logic [3:0] t_min1,
   input  logic [3:0] t_hrs0,
   input  logic [3:0] t_hrs1,
   input  logic       t_zero,
   output logic [5:0] cursor,
   output logic [3:0] n_sec0,
   output logic [3:0] n_sec1,
   output logic [3:0] n_min0,
   output logic [3:0] n_min1,
   output logic [3:0] n_hrs0,
   output logic [3:0] n_hrs1,
   output logic       load,
   output logic       run_en,
   output logic       alarm,
   output logic [2:0] state
);

   state_t           state_q, state_next;
   logic [3:0]       edit  [N_DIGITS];
   logic [3:0]       t_dig [N_DIGITS];
   logic [CNT_W-1:0] alarm_cnt;

   logic e_mode, e_left, e_right, e_up, e_start, any_edge;
   logic enter_set, do_up, do_left, do_right, cnt_inc, edit_nonzero;

   btn_edge u_edge_mode  (.clk(clk), .rst(rst), .btn(btn_mode),  .pulse(e_mode));
   btn_edge u_edge_left  (.clk(clk), .rst(rst), .btn(btn_left),  .pulse(e_left));
   btn_edge u_edge_right (.clk(clk), .rst(rst), .btn(btn_right), .pulse(e_right));
   btn_edge u_edge_up    (.clk(clk), .rst(rst), .btn(btn_up),    .pulse(e_up));
   btn_edge u_edge_start (.clk(clk), .rst(rst), .btn(btn_start), .pulse(e_start));

   assign any_edge = e_mode | e_left | e_right | e_up | e_start;

   assign t_dig[0] = t_sec0;
   assign t_dig[1] = t_sec1;
   assign t_dig[2] = t_min0;
   assign t_dig[3] = t_min1;
   assign t_dig[4] = t_hrs0;
   assign t_dig[5] = t_hrs1;

   always_comb begin
      edit_nonzero = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) edit_nonzero |= (edit[i] != 4'd0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_next;
   end

   // Each branch chain encodes the start > mode > up > left > right priority,
   // so at most one button is acted on per cycle.
   always_comb begin
      // NOTE: every output of this block is given a default first; any path
      // that leaves one unassigned would otherwise infer a latch.
      state_next = state_q;
      enter_set  = 1'b0;
      do_up      = 1'b0;
      do_left    = 1'b0;
      do_right   = 1'b0;
      cnt_inc    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (e_start) begin
               if (!t_zero) state_next = ST_RUN;
            end else if (e_mode) begin
               state_next = ST_SET;
               enter_set  = 1'b1;
            end
         end
         ST_SET: begin
            if (e_start)      state_next = edit_nonzero ? ST_RUN : ST_IDLE;
            else if (e_mode)  state_next = ST_IDLE;
            else if (e_up)    do_up      = 1'b1;
            else if (e_left)  do_left    = 1'b1;
            else if (e_right) do_right   = 1'b1;
         end
         ST_RUN: begin
            if (e_start)     state_next = ST_PAUSE;
            else if (t_zero) state_next = ST_ALARM;
         end
         ST_PAUSE: begin
            if (e_start) begin
               state_next = ST_RUN;
            end else if (e_mode) begin
               state_next = ST_SET;
               enter_set  = 1'b1;
            end
         end
         ST_ALARM: begin
            if (any_edge) begin
               state_next = ST_IDLE;
            end else if (tick_1hz) begin
               if (alarm_cnt == CNT_W'(ALARM_SECS - 1)) state_next = ST_IDLE;
               else                                     cnt_inc    = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Counter only runs while staying in ALARM, so it is always 0 on entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                         alarm_cnt <= '0;
      else if (state_next != ST_ALARM)  alarm_cnt <= '0;
      else if (cnt_inc)                 alarm_cnt <= alarm_cnt + 1'b1;
   end

   // NOTE: the edit digits are a handful of architectural registers, not a
   // RAM, so they are reset like any other state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_DIGITS; i++) edit[i] <= 4'd0;
         cursor <= CUR_SEC0;
      end else if (enter_set) begin
         for (int i = 0; i < N_DIGITS; i++) edit[i] <= t_dig[i];
         cursor <= CUR_SEC0;
      end else if (do_up) begin
         for (int i = 0; i < N_DIGITS; i++)
            if (cursor[i]) edit[i] <= digit_inc(edit[i], i);
      end else if (do_left) begin
         cursor <= {cursor[4:0], cursor[5]};
      end else if (do_right) begin
         cursor <= {cursor[0], cursor[5:1]};
      end
   end

   assign n_sec0 = edit[0];
   assign n_sec1 = edit[1];
   assign n_min0 = edit[2];
   assign n_min1 = edit[3];
   assign n_hrs0 = edit[4];
   assign n_hrs1 = edit[5];

   // Decoded straight from the state register so reset clears them at once.
   assign load   = (state_q == ST_SET);
   assign run_en = (state_q == ST_RUN) & tick_1hz;
   assign alarm  = (state_q == ST_ALARM);
   assign state  = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_ctrl -- directed self-checking bench for timer_ctrl. Expected values
// are pushed to a scoreboard queue as stimulus is applied and popped when the
// corresponding DUT output is sampled.
// -----------------------------------------------------------------------------
module tb_timer_ctrl;

   localparam int S_IDLE  = 0;
   localparam int S_SET   = 1;
   localparam int S_RUN   = 2;
   localparam int S_PAUSE = 3;
   localparam int S_ALARM = 4;

   // Button masks {start, mode, up, left, right}
   localparam logic [4:0] B_START = 5'b10000;
   localparam logic [4:0] B_MODE  = 5'b01000;
   localparam logic [4:0] B_UP    = 5'b00100;
   localparam logic [4:0] B_LEFT  = 5'b00010;
   localparam logic [4:0] B_RIGHT = 5'b00001;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick_1hz;
   logic       btn_mode, btn_left, btn_right, btn_up, btn_start;
   logic [3:0] t_sec0, t_sec1, t_min0, t_min1, t_hrs0, t_hrs1;
   logic       t_zero;
   logic [5:0] cursor;
   logic [3:0] n_sec0, n_sec1, n_min0, n_min1, n_hrs0, n_hrs1;
   logic       load, run_en, alarm;
   logic [2:0] state;

   always #5 clk = ~clk;

   timer_ctrl #(.ALARM_SECS(30), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
      .btn_mode(btn_mode), .btn_left(btn_left), .btn_right(btn_right),
      .btn_up(btn_up), .btn_start(btn_start),
      .t_sec0(t_sec0), .t_sec1(t_sec1), .t_min0(t_min0), .t_min1(t_min1),
      .t_hrs0(t_hrs0), .t_hrs1(t_hrs1), .t_zero(t_zero),
      .cursor(cursor),
      .n_sec0(n_sec0), .n_sec1(n_sec1), .n_min0(n_min0), .n_min1(n_min1),
      .n_hrs0(n_hrs0), .n_hrs1(n_hrs1),
      .load(load), .run_en(run_en), .alarm(alarm), .state(state)
   );

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   task automatic exp_push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      vectors++;
      if (sb.size() == 0) begin
         miscompares++;
         $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_btns(input logic [4:0] b);
      {btn_start, btn_mode, btn_up, btn_left, btn_right} = b;
   endtask

   // Returns 1 ns after the clock edge that acted on the press.
   task automatic press(input logic [4:0] b);
      @(posedge clk); #1 set_btns(b);
      @(posedge clk); #1 set_btns(5'b0);
   endtask

   // One tick cycle; run_en is sampled mid-cycle while the tick is high.
   task automatic do_tick(output logic re);
      @(posedge clk); #1 tick_1hz = 1'b1;
      #2 re = run_en;
      @(posedge clk); #1 tick_1hz = 1'b0;
   endtask

   task automatic set_t(input logic [3:0] s0, s1, m0, m1, h0, h1);
      {t_sec0, t_sec1, t_min0, t_min1, t_hrs0, t_hrs1} = {s0, s1, m0, m1, h0, h1};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic re;
      int   pulses;
      logic [31:0] wrap_seq [6];
      wrap_seq[0] = 1; wrap_seq[1] = 2; wrap_seq[2] = 3;
      wrap_seq[3] = 4; wrap_seq[4] = 5; wrap_seq[5] = 0;

      rst = 1'b0; tick_1hz = 1'b0; set_btns(5'b0);
      set_t(0, 0, 0, 0, 0, 0); t_zero = 1'b1;
      btn_mode = 1'b1;                       // held across reset release

      // Reset values
      repeat (3) @(posedge clk); #2;
      exp_push("rst_state", S_IDLE);   check(state);
      exp_push("rst_cursor", 6'b000001); check(cursor);
      exp_push("rst_load", 0);         check(load);
      exp_push("rst_run_en", 0);       check(run_en);
      exp_push("rst_alarm", 0);        check(alarm);
      exp_push("rst_n_sec0", 0);       check(n_sec0);
      exp_push("rst_n_hrs1", 0);       check(n_hrs1);

      // A button held through reset release is not a press
      rst = 1'b1;
      cyc(3);
      exp_push("held_mode_no_edge", S_IDLE); check(state);
      btn_mode = 1'b0;
      cyc(2);

      // Start with t_zero=1 is ignored in IDLE
      press(B_START);
      exp_push("idle_start_tzero", S_IDLE); check(state);

      // Enter SET from zero digits
      press(B_MODE);
      exp_push("set_entry_state", S_SET);   check(state);
      exp_push("set_entry_load", 1);        check(load);
      exp_push("set_entry_cursor", 6'b000001); check(cursor);

      // Tens-of-seconds wraps 5 -> 0
      press(B_LEFT);
      exp_push("left_to_sec1", 6'b000010); check(cursor);
      for (int i = 0; i < 6; i++) begin
         press(B_UP);
         exp_push($sformatf("sec1_wrap_%0d", i), wrap_seq[i]); check(n_sec1);
      end

      // Cursor wrap in both directions
      press(B_RIGHT);
      exp_push("right_to_sec0", 6'b000001); check(cursor);
      press(B_RIGHT);
      exp_push("right_wrap_hrs1", 6'b100000); check(cursor);
      press(B_LEFT);
      exp_push("left_wrap_sec0", 6'b000001); check(cursor);

      // Units digit wraps 9 -> 0
      repeat (9) press(B_UP);
      exp_push("sec0_at_9", 9); check(n_sec0);
      press(B_UP);
      exp_push("sec0_wrap_0", 0); check(n_sec0);

      // Start with all edit digits zero returns to IDLE
      press(B_START);
      exp_push("set_start_zero", S_IDLE); check(state);

      // Set-and-run
      press(B_MODE);
      exp_push("sr_state_set", S_SET); check(state);
      repeat (3) begin
         press(B_UP);
         exp_push("sr_load_up", 1); check(load);
      end
      exp_push("sr_n_sec0", 3); check(n_sec0);
      press(B_LEFT);
      press(B_UP);
      press(B_UP);
      exp_push("sr_n_sec1", 2); check(n_sec1);
      exp_push("sr_load_end", 1); check(load);
      t_zero = 1'b0;
      press(B_START);
      exp_push("sr_state_run", S_RUN); check(state);
      exp_push("sr_load_run", 0);      check(load);
      pulses = 0;
      repeat (25) begin
         do_tick(re);
         if (re) pulses++;
         cyc(1);
         if (run_en) pulses++;               // must stay low between ticks
      end
      exp_push("sr_run_en_pulses", 25); check(pulses);

      // Pause: no counting for three ticks, then resume
      press(B_START);
      exp_push("pause_state", S_PAUSE); check(state);
      pulses = 0;
      repeat (3) begin
         do_tick(re);
         if (re) pulses++;
      end
      exp_push("pause_run_en", 0);       check(pulses);
      exp_push("pause_hold", S_PAUSE);   check(state);
      press(B_START);
      exp_push("resume_state", S_RUN);   check(state);
      do_tick(re);
      exp_push("resume_run_en", 1);      check(re);

      // Tick and start in the same RUN cycle
      @(posedge clk); #1 tick_1hz = 1'b1; btn_start = 1'b1;
      #2 exp_push("tick_start_run_en", 1); check(run_en);
      @(posedge clk); #1 tick_1hz = 1'b0; btn_start = 1'b0;
      exp_push("tick_start_pause", S_PAUSE); check(state);

      // PAUSE -> SET reloads edits from the datapath
      set_t(4'd4, 4'd5, 4'd6, 4'd1, 4'd8, 4'd2);
      press(B_MODE);
      exp_push("reload_state", S_SET);     check(state);
      exp_push("reload_cursor", 6'b000001); check(cursor);
      exp_push("reload_sec0", 4);          check(n_sec0);
      exp_push("reload_sec1", 5);          check(n_sec1);
      exp_push("reload_min0", 6);          check(n_min0);
      exp_push("reload_min1", 1);          check(n_min1);
      exp_push("reload_hrs0", 8);          check(n_hrs0);
      exp_push("reload_hrs1", 2);          check(n_hrs1);
      press(B_MODE);
      exp_push("set_mode_idle", S_IDLE);   check(state);

      // Expiry: ALARM the cycle after t_zero is seen, then 30 ticks
      press(B_START);
      exp_push("exp_run", S_RUN); check(state);
      @(posedge clk); #1 t_zero = 1'b1;
      cyc(1);
      exp_push("exp_alarm_state", S_ALARM); check(state);
      exp_push("exp_alarm_on", 1);          check(alarm);
      exp_push("exp_run_en_off", 0);        check(run_en);
      pulses = 0;
      repeat (29) begin
         do_tick(re);
         if (re) pulses++;
      end
      exp_push("alarm_run_en_ticks", 0);    check(pulses);
      exp_push("alarm_29_state", S_ALARM);  check(state);
      exp_push("alarm_29_on", 1);           check(alarm);
      do_tick(re);
      exp_push("alarm_30_state", S_IDLE);   check(state);
      exp_push("alarm_30_off", 0);          check(alarm);

      // Any button clears ALARM
      t_zero = 1'b0;
      press(B_START);
      @(posedge clk); #1 t_zero = 1'b1;
      cyc(1);
      exp_push("btn_alarm_state", S_ALARM); check(state);
      press(B_RIGHT);
      exp_push("btn_alarm_clear", S_IDLE);  check(state);

      // Start and mode together in IDLE act as start
      t_zero = 1'b0;
      press(B_START | B_MODE);
      exp_push("start_mode_prio", S_RUN);   check(state);

      // Reset mid-RUN drops run_en without a clock edge
      @(posedge clk); #1 tick_1hz = 1'b1;
      #1 exp_push("pre_rst_run_en", 1);     check(run_en);
      #1 rst = 1'b0;
      #1 exp_push("rst_mid_run_en", 0);     check(run_en);
      exp_push("rst_mid_state", S_IDLE);    check(state);
      tick_1hz = 1'b0;
      #2 rst = 1'b1;
      cyc(2);

      // Reset mid-ALARM drops alarm without a clock edge
      press(B_START);
      @(posedge clk); #1 t_zero = 1'b1;
      cyc(1);
      exp_push("pre_rst_alarm", 1);         check(alarm);
      #2 rst = 1'b0;
      #1 exp_push("rst_mid_alarm", 0);      check(alarm);
      #2 rst = 1'b1;
      cyc(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
